// File: rtl/cpu_bus_axi_master_pkg.sv
// Shared address-map codes, AXI response codes
// and FSM state encodings for the CPU bus master.
package cpu_bus_axi_master_pkg;

  localparam logic [2:0] ADDR_TYPE_NOT_OP  = 3'd0;
  localparam logic [2:0] ADDR_TYPE_ROM     = 3'd1;
  localparam logic [2:0] ADDR_TYPE_RAM     = 3'd2;
  localparam logic [2:0] ADDR_TYPE_LED     = 3'd3;
  localparam logic [2:0] ADDR_TYPE_GPIO    = 3'd4;
  localparam logic [2:0] ADDR_TYPE_BUTTON  = 3'd5;
  localparam logic [2:0] ADDR_TYPE_AXI     = 3'd6;
  localparam logic [2:0] ADDR_TYPE_UNKNOWN = 3'd7;

  localparam logic [31:0] DRAM_BASE = 32'h8000_0000;
  localparam logic [31:0] UART_TX   = 32'h4000_0000;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_B    = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_R    = 3'd4;
  localparam logic [2:0] ST_INT  = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  function automatic logic is_int_type(
    input logic [2:0] t
  );
    return (t == ADDR_TYPE_ROM) ||
           (t == ADDR_TYPE_RAM) ||
           (t == ADDR_TYPE_LED) ||
           (t == ADDR_TYPE_GPIO) ||
           (t == ADDR_TYPE_BUTTON);
  endfunction

  function automatic logic [7:0] rd_byte(
    input logic [31:0] w,
    input logic [1:0]  a
  );
    return w[{a, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/axi_lite_watchdog.sv
// Phase watchdog: counts cycles spent in one AXI
// phase and pulses expire once the limit is hit.
module axi_lite_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic run,
  input  logic clr,
  output logic expire
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // cycle counter; the clearing cycle itself counts as one
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= W'(1);
    end else if (cnt != W'(LIMIT)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = run && !clr &&
                  (cnt == W'(LIMIT - 1));

endmodule

// File: rtl/cpu_bus_axi_master.sv
// Executes a decoded CPU bus request as one AXI4-Lite
// transaction or a one-cycle internal port access.
module cpu_bus_axi_master
  import cpu_bus_axi_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int INT_RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req,
  input  logic [31:0] A32,
  input  logic [31:0] D32,
  input  logic [3:0]  wstrb,
  input  logic        is_read,
  input  logic [2:0]  addr_type,
  output logic        rdy,
  output logic [7:0]  rdata,
  output logic [31:0] m_awaddr,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        int_stb,
  output logic [2:0]  int_type,
  output logic [11:0] int_addr,
  output logic        int_we,
  output logic [7:0]  int_wdata,
  input  logic [7:0]  int_rdata,
  output logic        resp_err,
  output logic        timeout_err
);

  logic [2:0]  st;
  logic [2:0]  st_d;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;
  logic [2:0]  type_q;
  logic        rd_q;
  logic        aw_done;
  logic        w_done;
  logic [1:0]  int_cnt;
  logic        aw_hs;
  logic        w_hs;
  logic        wd_run;
  logic        wd_clr;
  logic        wd_expire;

  assign aw_hs = m_awvalid && m_awready;
  assign w_hs  = m_wvalid && m_wready;

  assign m_awaddr  = addr_q;
  assign m_araddr  = addr_q;
  assign m_wdata   = data_q;
  assign m_wstrb   = strb_q;
  assign int_type  = type_q;
  assign int_addr  = addr_q[11:0];
  assign int_wdata = data_q[7:0];

  // a dropped req hides a late completion
  assign rdy = (st == ST_DONE) && req;

  assign wd_run = (st == ST_WR) || (st == ST_B) ||
                  (st == ST_RD) || (st == ST_R);
  assign wd_clr = (st != st_d);

  // previous state, so the watchdog restarts per phase
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_d <= ST_IDLE;
    end else begin
      st_d <= st;
    end
  end

  axi_lite_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .rstn   (rstn),
    .run    (wd_run),
    .clr    (wd_clr),
    .expire (wd_expire)
  );

  // request FSM driving AXI and internal handshakes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st          <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      strb_q      <= '0;
      type_q      <= '0;
      rd_q        <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      int_cnt     <= '0;
      rdata       <= '0;
      m_awvalid   <= 1'b0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
      int_stb     <= 1'b0;
      int_we      <= 1'b0;
      resp_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      unique case (st)
        ST_IDLE: begin
          if (req && addr_type != ADDR_TYPE_NOT_OP) begin
            addr_q  <= A32;
            data_q  <= D32;
            strb_q  <= wstrb;
            type_q  <= addr_type;
            rd_q    <= is_read;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            int_cnt <= '0;
            unique case (1'b1)
              (addr_type == ADDR_TYPE_AXI && !is_read): begin
                st        <= ST_WR;
                m_awvalid <= 1'b1;
                m_wvalid  <= 1'b1;
              end
              (addr_type == ADDR_TYPE_AXI && is_read): begin
                st        <= ST_RD;
                m_arvalid <= 1'b1;
              end
              is_int_type(addr_type): begin
                st      <= ST_INT;
                int_stb <= 1'b1;
                int_we  <= !is_read;
              end
              default: begin
                st    <= ST_DONE;
                rdata <= 8'hFF;
              end
            endcase
          end
        end
        ST_WR: begin
          if (aw_hs) begin
            m_awvalid <= 1'b0;
            aw_done   <= 1'b1;
          end
          if (w_hs) begin
            m_wvalid <= 1'b0;
            w_done   <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            st       <= ST_B;
            m_bready <= 1'b1;
          end
        end
        ST_B: begin
          if (m_bvalid) begin
            m_bready <= 1'b0;
            rdata    <= 8'h00;
            st       <= ST_DONE;
            if (m_bresp != RESP_OKAY) resp_err <= 1'b1;
          end
        end
        ST_RD: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            st        <= ST_R;
          end
        end
        ST_R: begin
          if (m_rvalid) begin
            m_rready <= 1'b0;
            rdata    <= rd_byte(m_rdata, addr_q[1:0]);
            st       <= ST_DONE;
            if (m_rresp != RESP_OKAY) resp_err <= 1'b1;
          end
        end
        ST_INT: begin
          int_stb <= 1'b0;
          int_we  <= 1'b0;
          if (int_cnt == 2'(INT_RD_LATENCY)) begin
            rdata <= rd_q ? int_rdata : 8'h00;
            st    <= ST_DONE;
          end else begin
            int_cnt <= int_cnt + 2'd1;
          end
        end
        ST_DONE: begin
          if (!req) st <= ST_IDLE;
        end
        default: st <= ST_IDLE;
      endcase
      if (wd_expire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_bus_axi_master.sv
// Bench for cpu_bus_axi_master: vector table,
// scoreboard queue and multi-cycle corner sequences.
module tb_cpu_bus_axi_master;
  import cpu_bus_axi_master_pkg::*;

  localparam int TO = 1024;

  typedef struct {
    logic [2:0]  atype;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] srd;
    logic [7:0]  ival;
    int          hold;
    logic [7:0]  exp_rd;
    int          exp_lat;
    int          exp_ar;
    int          exp_aw;
    int          exp_stb;
  } vec_t;

  typedef struct {
    logic [7:0] rdata;
    int         lat;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic        req;
  logic [31:0] A32;
  logic [31:0] D32;
  logic [3:0]  wstrb;
  logic        is_read;
  logic [2:0]  addr_type;
  logic        rdy;
  logic [7:0]  rdata;
  logic [31:0] m_awaddr;
  logic        m_awvalid;
  logic        m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wvalid;
  logic        m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid;
  logic        m_bready;
  logic [31:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rready;
  logic        int_stb;
  logic [2:0]  int_type;
  logic [11:0] int_addr;
  logic        int_we;
  logic [7:0]  int_wdata;
  logic [7:0]  int_rdata = 8'h00;
  logic        resp_err;
  logic        timeout_err;

  int          aw_delay;
  int          ar_delay;
  int          aw_wait;
  int          ar_wait;
  logic        aw_got;
  logic        w_got;
  logic [31:0] slv_rdata;
  logic [1:0]  slv_resp;
  logic [7:0]  int_val;

  int total;
  int bad;
  exp_t exp_q[$];
  vec_t vecs[8];

  cpu_bus_axi_master #(
    .TIMEOUT_CYCLES (TO),
    .INT_RD_LATENCY (1)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req         (req),
    .A32         (A32),
    .D32         (D32),
    .wstrb       (wstrb),
    .is_read     (is_read),
    .addr_type   (addr_type),
    .rdy         (rdy),
    .rdata       (rdata),
    .m_awaddr    (m_awaddr),
    .m_awvalid   (m_awvalid),
    .m_awready   (m_awready),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_wvalid    (m_wvalid),
    .m_wready    (m_wready),
    .m_bresp     (m_bresp),
    .m_bvalid    (m_bvalid),
    .m_bready    (m_bready),
    .m_araddr    (m_araddr),
    .m_arvalid   (m_arvalid),
    .m_arready   (m_arready),
    .m_rdata     (m_rdata),
    .m_rresp     (m_rresp),
    .m_rvalid    (m_rvalid),
    .m_rready    (m_rready),
    .int_stb     (int_stb),
    .int_type    (int_type),
    .int_addr    (int_addr),
    .int_we      (int_we),
    .int_wdata   (int_wdata),
    .int_rdata   (int_rdata),
    .resp_err    (resp_err),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign m_awready = m_awvalid && (aw_wait >= aw_delay);
  assign m_wready  = m_wvalid;
  assign m_arready = m_arvalid && (ar_wait >= ar_delay);

  // AXI4-Lite slave: programmable AW/AR wait, registered B/R
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aw_wait  <= 0;
      ar_wait  <= 0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      m_bvalid <= 1'b0;
      m_bresp  <= 2'b00;
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
      m_rresp  <= 2'b00;
    end else begin
      aw_wait <= (m_awvalid && !m_awready) ? aw_wait + 1 : 0;
      ar_wait <= (m_arvalid && !m_arready) ? ar_wait + 1 : 0;
      if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else begin
        if (m_awvalid && m_awready) aw_got <= 1'b1;
        if (m_wvalid && m_wready) w_got <= 1'b1;
        if (!m_bvalid &&
            (aw_got || (m_awvalid && m_awready)) &&
            (w_got || (m_wvalid && m_wready))) begin
          m_bvalid <= 1'b1;
          m_bresp  <= slv_resp;
        end
      end
      if (m_rvalid && m_rready) begin
        m_rvalid <= 1'b0;
      end else if (m_arvalid && m_arready) begin
        m_rvalid <= 1'b1;
        m_rdata  <= slv_rdata;
        m_rresp  <= slv_resp;
      end
    end
  end

  // internal port: data one cycle after the strobe
  always @(posedge clk) begin
    int_rdata <= int_stb ? int_val : 8'hEE;
  end

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic drive_txn(
    input  logic [2:0]  t,
    input  logic        rd,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  logic [3:0]  s,
    input  logic [31:0] srd,
    input  logic [7:0]  iv,
    input  logic [7:0]  exp_rd,
    input  int          exp_lat,
    input  int          hold,
    output int          nar,
    output int          naw,
    output int          nw,
    output int          nstb,
    output logic [11:0] saddr,
    output logic        swe,
    output logic [31:0] swd
  );
    exp_t e;
    int lat;
    bit got;
    nar = 0; naw = 0; nw = 0; nstb = 0;
    saddr = '0; swe = 1'b0; swd = '0;
    slv_rdata = srd;
    int_val = iv;
    addr_type = t; is_read = rd;
    A32 = a; D32 = d; wstrb = s;
    req = 1'b1;
    e.rdata = exp_rd;
    e.lat = exp_lat;
    exp_q.push_back(e);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      nar += int'(m_arvalid);
      naw += int'(m_awvalid);
      nw += int'(m_wvalid);
      if (m_wvalid) swd = m_wdata;
      if (int_stb) begin
        nstb++;
        saddr = int_addr;
        swe = int_we;
      end
      if (rdy) got = 1'b1;
    end
    e = exp_q.pop_front();
    if (!got) begin
      chk("rdy_timeout", 32'd0, 32'd1);
    end else begin
      chk("rdata", 32'(rdata), 32'(e.rdata));
      chk("latency", lat, e.lat);
    end
    // late input changes must not disturb DONE
    addr_type = ADDR_TYPE_UNKNOWN;
    A32 = ~a;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rdy_hold", 32'(rdy), 32'd1);
      chk("rdata_hold", 32'(rdata), 32'(e.rdata));
    end
    req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rdy_drop", 32'(rdy), 32'd0);
  endtask

  int          nar;
  int          naw;
  int          nw;
  int          nstb;
  int          nrr;
  int          nrdy;
  logic [11:0] saddr;
  logic        swe;
  logic [31:0] swd;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad = 0;
    aw_delay = 0;
    ar_delay = 0;
    slv_rdata = '0;
    slv_resp = RESP_OKAY;
    int_val = 8'h00;
    rstn = 1'b0;
    req = 1'b0;
    A32 = '0; D32 = '0; wstrb = '0;
    is_read = 1'b0;
    addr_type = ADDR_TYPE_NOT_OP;

    //        type rd addr wdata strb srd ival hold
    //        exp_rd lat ar aw stb
    vecs[0] = '{ADDR_TYPE_AXI, 1'b1, DRAM_BASE + 32'd2,
                32'h0, 4'h0, 32'h4433_2211, 8'h00, 0,
                8'h33, 3, 1, 0, 0};
    vecs[1] = '{ADDR_TYPE_AXI, 1'b1, DRAM_BASE,
                32'h0, 4'h0, 32'h4433_2211, 8'h00, 0,
                8'h11, 3, 1, 0, 0};
    vecs[2] = '{ADDR_TYPE_AXI, 1'b1, DRAM_BASE + 32'd7,
                32'h0, 4'h0, 32'hA1B2_C3D4, 8'h00, 1,
                8'hA1, 3, 1, 0, 0};
    vecs[3] = '{ADDR_TYPE_AXI, 1'b0, UART_TX,
                32'h41, 4'h1, 32'h0, 8'h00, 0,
                8'h00, 3, 0, 1, 0};
    vecs[4] = '{ADDR_TYPE_RAM, 1'b1, 32'h0000_0123,
                32'h0, 4'h0, 32'h0, 8'h5A, 4,
                8'h5A, 3, 0, 0, 1};
    vecs[5] = '{ADDR_TYPE_LED, 1'b0, 32'h0000_0010,
                32'h81, 4'h1, 32'h0, 8'h00, 0,
                8'h00, 3, 0, 0, 1};
    vecs[6] = '{ADDR_TYPE_UNKNOWN, 1'b1, 32'h1234_5678,
                32'h0, 4'h0, 32'h0, 8'h00, 2,
                8'hFF, 1, 0, 0, 0};
    vecs[7] = '{ADDR_TYPE_ROM, 1'b1, 32'hFFFF_F456,
                32'h0, 4'h0, 32'h0, 8'hC3, 0,
                8'hC3, 3, 0, 0, 1};

    repeat (2) @(negedge clk);
    chk("rst_outputs", 32'(|{rdy, rdata, m_awvalid,
        m_wvalid, m_bready, m_arvalid, m_rready,
        int_stb, int_we, m_awaddr, int_type}), 32'd0);
    chk("rst_sticky", 32'({resp_err, timeout_err}), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      drive_txn(vecs[i].atype, vecs[i].rd, vecs[i].addr,
                vecs[i].wdata, vecs[i].strb, vecs[i].srd,
                vecs[i].ival, vecs[i].exp_rd,
                vecs[i].exp_lat, vecs[i].hold,
                nar, naw, nw, nstb, saddr, swe, swd);
      chk($sformatf("v%0d_ar", i), nar, vecs[i].exp_ar);
      chk($sformatf("v%0d_aw", i), naw, vecs[i].exp_aw);
      chk($sformatf("v%0d_w", i), nw, vecs[i].exp_aw);
      chk($sformatf("v%0d_stb", i), nstb, vecs[i].exp_stb);
      if (vecs[i].exp_aw != 0)
        chk($sformatf("v%0d_wdata", i), swd, vecs[i].wdata);
      if (vecs[i].exp_stb != 0) begin
        chk($sformatf("v%0d_iaddr", i), 32'(saddr),
            32'(vecs[i].addr[11:0]));
        chk($sformatf("v%0d_iwe", i), 32'(swe),
            32'(!vecs[i].rd));
        if (!vecs[i].rd)
          chk($sformatf("v%0d_iwdata", i), 32'(int_wdata),
              32'(vecs[i].wdata[7:0]));
      end
    end
    chk("table_sticky", 32'({resp_err, timeout_err}), 32'd0);

    // AW ready arrives in the third valid cycle, W at once
    aw_delay = 2;
    drive_txn(ADDR_TYPE_AXI, 1'b0, UART_TX, 32'h41, 4'h1,
              32'h0, 8'h00, 8'h00, 5, 0,
              nar, naw, nw, nstb, saddr, swe, swd);
    chk("slow_aw_cycles", naw, 3);
    chk("slow_w_cycles", nw, 1);
    chk("slow_wdata", swd, 32'h41);
    chk("slow_resp_err", 32'(resp_err), 32'd0);
    aw_delay = 0;

    // SLVERR read sets the sticky flag, OKAY keeps it
    slv_resp = 2'b10;
    drive_txn(ADDR_TYPE_AXI, 1'b1, DRAM_BASE + 32'd1, 32'h0,
              4'h0, 32'h00AA_5500, 8'h00, 8'h55, 3, 0,
              nar, naw, nw, nstb, saddr, swe, swd);
    chk("slverr_set", 32'(resp_err), 32'd1);
    slv_resp = RESP_OKAY;
    drive_txn(ADDR_TYPE_AXI, 1'b1, DRAM_BASE, 32'h0,
              4'h0, 32'h1234_5678, 8'h00, 8'h78, 3, 0,
              nar, naw, nw, nstb, saddr, swe, swd);
    chk("slverr_sticky", 32'(resp_err), 32'd1);

    // NOT_OP with req high never answers
    addr_type = ADDR_TYPE_NOT_OP;
    A32 = DRAM_BASE;
    req = 1'b1;
    nrdy = 0; nar = 0; nstb = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      nrdy += int'(rdy);
      nar += int'(m_arvalid | m_awvalid);
      nstb += int'(int_stb);
    end
    chk("notop_rdy", nrdy, 0);
    chk("notop_axi", nar, 0);
    chk("notop_int", nstb, 0);
    req = 1'b0;
    @(negedge clk);

    // req withdrawn after launch: AXI still completes
    ar_delay = 2;
    slv_rdata = 32'hDEAD_BEEF;
    addr_type = ADDR_TYPE_AXI;
    is_read = 1'b1;
    A32 = DRAM_BASE;
    req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    nar = int'(m_arvalid);
    nrr = 0;
    nrdy = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      nrdy += int'(rdy);
      nar += int'(m_arvalid);
      nrr += int'(m_rready);
    end
    chk("drop_rdy", nrdy, 0);
    chk("drop_ar_cycles", nar, 3);
    chk("drop_rready", nrr, 1);
    ar_delay = 0;
    drive_txn(ADDR_TYPE_AXI, 1'b1, DRAM_BASE + 32'd2, 32'h0,
              4'h0, 32'h0077_0000, 8'h00, 8'h77, 3, 0,
              nar, naw, nw, nstb, saddr, swe, swd);

    // stalled AR: watchdog fires, valid stays, reset clears
    ar_delay = 100000;
    addr_type = ADDR_TYPE_AXI;
    is_read = 1'b1;
    A32 = DRAM_BASE;
    req = 1'b1;
    for (int c = 1; c <= TO + 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == TO - 24)
        chk("to_early", 32'(timeout_err), 32'd0);
    end
    chk("to_set", 32'(timeout_err), 32'd1);
    chk("to_arvalid", 32'(m_arvalid), 32'd1);
    chk("to_no_rdy", 32'(rdy), 32'd0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_outputs", 32'(|{rdy, rdata, m_awvalid,
        m_wvalid, m_bready, m_arvalid, m_rready,
        int_stb, int_we, m_araddr, int_addr}), 32'd0);
    chk("mid_rst_timeout", 32'(timeout_err), 32'd0);
    chk("mid_rst_resp", 32'(resp_err), 32'd0);
    req = 1'b0;
    ar_delay = 0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    drive_txn(ADDR_TYPE_AXI, 1'b1, DRAM_BASE + 32'd3, 32'h0,
              4'h0, 32'h9988_7766, 8'h00, 8'h99, 3, 0,
              nar, naw, nw, nstb, saddr, swe, swd);
    chk("post_rst_ar", nar, 1);
    chk("post_rst_sticky", 32'({resp_err, timeout_err}),
        32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_bus_axi_master.md
Name: cpu_bus_axi_master

Overview:
Downstream of the CPU-side address/strobe decoder: takes the decoded bus request (A32, D32, wstrb, is_read, addr_type) and executes it. AXI-typed requests run as a single AXI4-Lite master transaction; internal types (ROM/RAM/LED/GPIO/BUTTON) run as a one-cycle internal port access. The block returns an 8-bit read byte and a ready level that the CPU wait logic uses to stretch the bus cycle.

Parameters:
TIMEOUT_CYCLES, 1024, cycles in one AXI phase before timeout_err sets (watchdog only; never aborts a transaction)
INT_RD_LATENCY, 1, cycles from int_stb to a valid int_rdata (1 or 2)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
req  in  1  level; high while the CPU bus cycle (RD or WR) is active
A32  in  32  decoded address
D32  in  32  decoded write data (byte replicated for memory writes)
wstrb  in  4  decoded write strobes
is_read  in  1  1 = read
addr_type  in  3  ADDR_TYPE_* code
rdy  out  1  cycle complete; CPU may end bus cycle
rdata  out  8  read byte, valid while rdy
m_awaddr/m_awvalid/m_awready  out/out/in  32/1/1  AXI4-Lite AW
m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  32/4/1/1  AXI4-Lite W
m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  AXI4-Lite B
m_araddr/m_arvalid/m_arready  out/out/in  32/1/1  AXI4-Lite AR
m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  32/2/1/1  AXI4-Lite R
int_stb  out  1  one-cycle internal access strobe
int_type  out  3  latched addr_type for the internal access
int_addr  out  12  latched A32[11:0]
int_we  out  1  internal write
int_wdata  out  8  latched D32[7:0]
int_rdata  in  8  internal read data
resp_err  out  1  sticky; set on any BRESP/RRESP != OKAY
timeout_err  out  1  sticky; set when the watchdog expires

Behaviour:
- Reset: every output is 0, state is IDLE, both sticky flags are cleared. Only rstn clears the sticky flags.
- IDLE: when req=1 and addr_type != NOT_OP, latch all inputs and branch:
  - AXI with is_read=0 -> WR
  - AXI with is_read=1 -> RD
  - ROM/RAM/LED/GPIO/BUTTON -> INT
  - UNKNOWN -> DONE with rdata=8'hFF
  - NOT_OP or req=0 -> stay in IDLE.
- WR: assert awvalid and wvalid on the entry cycle. Each valid drops in the cycle after its own handshake (AW and W complete independently, in either order). Once both are done -> B. In B, bready=1; on bvalid, record bresp -> DONE.
- RD: assert arvalid until arready. Then go to R with rready=1; on rvalid, capture rdata32 and rresp -> DONE.
- Valid signals never drop before their ready. Addresses and data stay stable while valid.
- INT: int_stb high for exactly one cycle, int_we=!is_read. Wait INT_RD_LATENCY cycles, capture int_rdata -> DONE. A write goes to DONE after the same wait.
- AXI read byte select: rdata = rdata32[8*A32[1:0] +: 8]. Internal reads return int_rdata directly.
- DONE: rdy=1 and rdata is held until req=0, then -> IDLE with rdy=0. A new request needs req to deassert first, so there is no back-to-back re-trigger on a held req.
- Watchdog: counter runs only in WR/B/RD/R and clears on every state change. Reaching TIMEOUT_CYCLES sets timeout_err; the transaction continues.
- Changes on addr_type, A32 or other inputs after latching are ignored.
- If req drops mid-transaction, the AXI transaction still completes. DONE then sees req=0 and returns to IDLE the next cycle without a visible rdy.
- Reset mid-transaction drops all valids immediately. The AXI slave is reset by the same rstn.
- Latency with zero-wait slaves: AXI read rdy at cycle 3 after req; AXI write rdy at cycle 3; internal rdy at 1+INT_RD_LATENCY+1.

Decomposition:
- ADDR_TYPE_* codes and the AXI base addresses stay in the shared address-map include.
- Add a state enum (IDLE, WR, B, RD, R, INT, DONE) and the RESP_OKAY constant to the same shared package.
- One natural sub-module: axi_lite_watchdog (counter, clear, expire pulse).

Test Plan:
- AXI read, A32=DRAM_BASE+2, slave returns rdata=32'h44332211 with 0 waits -> rdy at cycle 3, rdata=8'h33; arvalid asserted for exactly 1 cycle.
- AXI write, A32=UART_TX, D32=8'h41, wstrb=1; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles, rdy after bvalid, resp_err=0.
- AXI read with rresp=2'b10 -> rdy asserted, resp_err=1; it stays 1 across a following OKAY transaction until rstn.
- Internal RAM read, A32=12'h123 -> int_stb for 1 cycle with int_addr=12'h123 and int_we=0; int_rdata=8'h5A -> rdata=8'h5A, rdy held until req drops.
- UNKNOWN read -> rdy on the next cycle, rdata=8'hFF, no AXI or internal activity. NOT_OP with req=1 -> no response.
- arready held low for TIMEOUT_CYCLES+5 -> timeout_err=1 and arvalid still high; rstn pulse mid-wait -> all outputs 0 and timeout_err cleared.
